// File: rtl/keypad_hex_entry.sv
// Assembles decoded keypad digits into a hex entry, MSD first.
// Commits explicitly or when full; clear and inactivity timeout discard the entry.
module keypad_hex_entry #(
   parameter int NUM_DIGITS     = 4,
   parameter int TIMEOUT_CYCLES = 50000000,
   parameter int TMR_W          = $clog2(TIMEOUT_CYCLES),
   parameter int CNT_W          = $clog2(NUM_DIGITS + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    key_pulse,
   input  logic [3:0]              key_value,
   input  logic                    commit,
   input  logic                    clear,
   output logic [4*NUM_DIGITS-1:0] edit_value,
   output logic [CNT_W-1:0]        digit_count,
   output logic                    entry_active,
   output logic [4*NUM_DIGITS-1:0] entry_value,
   output logic                    entry_valid,
   output logic                    entry_timeout
);

   localparam int W = 4 * NUM_DIGITS;

   typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

   state_t           state, state_nxt;
   logic [W-1:0]     edit_nxt, eval_nxt;
   logic [CNT_W-1:0] cnt_nxt, cnt_inc;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic             valid_nxt, tout_nxt;

   assign cnt_inc = digit_count + CNT_W'(1);

   always_comb begin
      state_nxt = state;
      edit_nxt  = edit_value;
      cnt_nxt   = digit_count;
      timer_nxt = timer;
      eval_nxt  = entry_value;
      valid_nxt = 1'b0;
      tout_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (key_pulse) begin
               edit_nxt  = W'(key_value);
               cnt_nxt   = CNT_W'(1);
               timer_nxt = '0;
               state_nxt = (NUM_DIGITS == 1) ? DONE : ENTRY;
            end
         end
         ENTRY: begin
            if (clear) begin
               edit_nxt  = '0;
               cnt_nxt   = '0;
               timer_nxt = '0;
               state_nxt = IDLE;
            end else if (commit) begin
               state_nxt = DONE;
            end else if (key_pulse) begin
               edit_nxt  = W'({edit_value, key_value});
               cnt_nxt   = cnt_inc;
               timer_nxt = '0;
               if (cnt_inc == CNT_W'(NUM_DIGITS)) state_nxt = DONE;
            end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
               edit_nxt  = '0;
               cnt_nxt   = '0;
               timer_nxt = '0;
               tout_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer + TMR_W'(1);
            end
         end
         DONE: begin
            // Inputs are ignored here; the decoder never pulses on back-to-back cycles.
            eval_nxt  = edit_value;
            valid_nxt = 1'b1;
            edit_nxt  = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         edit_value    <= '0;
         digit_count   <= '0;
         timer         <= '0;
         entry_value   <= '0;
         entry_valid   <= 1'b0;
         entry_timeout <= 1'b0;
         entry_active  <= 1'b0;
      end else begin
         state         <= state_nxt;
         edit_value    <= edit_nxt;
         digit_count   <= cnt_nxt;
         timer         <= timer_nxt;
         entry_value   <= eval_nxt;
         entry_valid   <= valid_nxt;
         entry_timeout <= tout_nxt;
         entry_active  <= (state_nxt == ENTRY);
      end
   end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Scoreboard bench: a 4-digit and a 1-digit instance share one random/directed key stream;
// a digit-arithmetic model queues per-cycle expectations that a negedge monitor checks.
module tb_keypad_hex_entry;

   localparam int T = 20;

   logic        clk = 1'b0, reset = 1'b1;
   logic        key_pulse = 1'b0, commit = 1'b0, clear = 1'b0;
   logic [3:0]  key_value = 4'h0;

   logic [15:0] edit_a, ev_a;
   logic [2:0]  cnt_a;
   logic        act_a, valid_a, to_a;
   logic [3:0]  edit_b, ev_b;
   logic [0:0]  cnt_b;
   logic        act_b, valid_b, to_b;

   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   keypad_hex_entry #(.NUM_DIGITS(4), .TIMEOUT_CYCLES(T)) dut_a (
      .clk(clk), .reset(reset), .key_pulse(key_pulse), .key_value(key_value),
      .commit(commit), .clear(clear), .edit_value(edit_a), .digit_count(cnt_a),
      .entry_active(act_a), .entry_value(ev_a), .entry_valid(valid_a), .entry_timeout(to_a));

   keypad_hex_entry #(.NUM_DIGITS(1), .TIMEOUT_CYCLES(T)) dut_b (
      .clk(clk), .reset(reset), .key_pulse(key_pulse), .key_value(key_value),
      .commit(commit), .clear(clear), .edit_value(edit_b), .digit_count(cnt_b),
      .entry_active(act_b), .entry_value(ev_b), .entry_valid(valid_b), .entry_timeout(to_b));

   typedef struct {
      logic [31:0] edit;
      int          cnt;
      bit          act;
      logic [31:0] ev;
      bit          vld;
      bit          to;
   } exp_t;

   exp_t q0[$], q1[$];

   // model state per instance: entry held as a number, digits appended by val*16+d
   int unsigned m_val[2], m_ev[2];
   int          m_cnt[2], m_idle[2];
   bit          m_open[2], m_done[2];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic mreset();
      for (int i = 0; i < 2; i++) begin
         m_val[i] = 0; m_ev[i] = 0; m_cnt[i] = 0; m_idle[i] = 0;
         m_open[i] = 0; m_done[i] = 0;
      end
   endtask

   function automatic exp_t step(int i, int n, bit kp, logic [3:0] kv, bit cm, bit cl);
      exp_t e;
      e.vld = 0; e.to = 0;
      if (m_done[i]) begin
         m_ev[i] = m_val[i]; e.vld = 1;
         m_val[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
      end else if (!m_open[i]) begin
         if (kp) begin
            m_val[i] = kv; m_cnt[i] = 1; m_idle[i] = 0;
            if (n == 1) m_done[i] = 1; else m_open[i] = 1;
         end
      end else if (cl) begin
         m_val[i] = 0; m_cnt[i] = 0; m_open[i] = 0;
      end else if (cm) begin
         m_open[i] = 0; m_done[i] = 1;
      end else if (kp) begin
         m_val[i] = m_val[i] * 16 + kv; m_cnt[i]++; m_idle[i] = 0;
         if (m_cnt[i] == n) begin m_open[i] = 0; m_done[i] = 1; end
      end else if (m_idle[i] == T - 1) begin
         m_val[i] = 0; m_cnt[i] = 0; m_open[i] = 0; e.to = 1;
      end else begin
         m_idle[i]++;
      end
      e.edit = m_val[i]; e.cnt = m_cnt[i]; e.act = m_open[i]; e.ev = m_ev[i];
      return e;
   endfunction

   // called at posedge+1; expectations are queued right after the edge they describe
   task automatic cyc(bit kp, logic [3:0] kv, bit cm, bit cl);
      exp_t e0, e1;
      key_pulse = kp; key_value = kv; commit = cm; clear = cl;
      e0 = step(0, 4, kp, kv, cm, cl);
      e1 = step(1, 1, kp, kv, cm, cl);
      @(posedge clk);
      q0.push_back(e0);
      q1.push_back(e1);
      #1;
      key_pulse = 0; commit = 0; clear = 0;
      key_value = 4'($urandom);
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) cyc(0, 4'h0, 0, 0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset) begin
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("a_edit", 32'(edit_a), e.edit);
            chk("a_count", 32'(cnt_a), 32'(e.cnt));
            chk("a_active", 32'(act_a), 32'(e.act));
            chk("a_value", 32'(ev_a), e.ev);
            chk("a_valid", 32'(valid_a), 32'(e.vld));
            chk("a_timeout", 32'(to_a), 32'(e.to));
         end else if (valid_a || to_a) begin
            chk("a_unexpected_strobe", {30'd0, valid_a, to_a}, 32'd0);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("b_edit", 32'(edit_b), e.edit);
            chk("b_count", 32'(cnt_b), 32'(e.cnt));
            chk("b_active", 32'(act_b), 32'(e.act));
            chk("b_value", 32'(ev_b), e.ev);
            chk("b_valid", 32'(valid_b), 32'(e.vld));
            chk("b_timeout", 32'(to_b), 32'(e.to));
         end else if (valid_b || to_b) begin
            chk("b_unexpected_strobe", {30'd0, valid_b, to_b}, 32'd0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit last_kp;
      int r;
      mreset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_edit", 32'(edit_a), 32'd0);
      chk("rst_valid", {30'd0, valid_a, act_a}, 32'd0);
      reset = 0;

      // mid-entry reset discards silently
      cyc(1, 4'h1, 0, 0); idle(1); cyc(1, 4'h2, 0, 0);
      @(negedge clk); #1;
      reset = 1; #1;
      chk("rst_mid_edit", 32'(edit_a), 32'd0);
      chk("rst_mid_count", 32'(cnt_a), 32'd0);
      chk("rst_mid_flags", {28'd0, act_a, valid_a, to_a, valid_b}, 32'd0);
      chk("rst_mid_value", {16'd0, ev_a}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 0; mreset();
      idle(3);

      // auto-commit on full buffer
      cyc(1, 4'hA, 0, 0); idle(2); cyc(1, 4'h5, 0, 0); idle(2);
      cyc(1, 4'h0, 0, 0); idle(2);
      chk("edit_0A50", 32'(edit_a), 32'h0A50);
      cyc(1, 4'hF, 0, 0); idle(1);
      chk("auto_A50F", 32'(ev_a), 32'hA50F);
      idle(2);

      // explicit commit, then commit in IDLE is ignored
      cyc(1, 4'h7, 0, 0); idle(1); cyc(1, 4'hC, 0, 0); idle(1);
      cyc(0, 4'h0, 1, 0); idle(2);
      chk("commit_007C", 32'(ev_a), 32'h007C);
      cyc(0, 4'h0, 1, 0); idle(2);

      // clear beats commit; commit beats a same-cycle key
      cyc(1, 4'h3, 0, 0); idle(1); cyc(1, 4'h4, 0, 0); idle(1);
      cyc(0, 4'h0, 1, 1); idle(2);
      chk("clear_keeps", 32'(ev_a), 32'h007C);
      cyc(1, 4'h8, 0, 0); idle(1); cyc(1, 4'h9, 1, 0); idle(2);
      chk("commit_drops_9", 32'(ev_a), 32'h0008);

      // key on the expiry cycle wins, then a real timeout
      cyc(1, 4'h2, 0, 0); idle(T - 1); cyc(1, 4'h6, 0, 0);
      chk("expiry_key_0026", 32'(edit_a), 32'h0026);
      idle(T + 3);

      // random traffic; decoder never pulses on consecutive cycles
      last_kp = 0;
      for (int it = 0; it < 600; it++) begin
         r = $urandom_range(0, 99);
         if (r < 5) begin
            idle($urandom_range(15, 25));
            last_kp = 0;
         end else begin
            bit kp;
            kp = !last_kp && (r < 44);
            cyc(kp, 4'($urandom), (r >= 40 && r < 50), (r >= 48 && r < 54));
            last_kp = kp;
         end
      end
      idle(4);
      @(negedge clk); #1;
      chk("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
